// File: rtl/cspc_context_scheduler.sv
// Round-robin context scheduler for a shared pipelined core: picks one eligible
// context per cycle, tracks its word through the core and steers the result back out.
module cspc_context_scheduler #(
    parameter  int NUM_PORTS    = 4,
    parameter  int PIPE_LATENCY = 3,
    localparam int SELECT_WIDTH = $clog2(NUM_PORTS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [0:NUM_PORTS-1]    avail_inarray,
    input  logic [0:NUM_PORTS-1]    ready_outarray,
    output logic [SELECT_WIDTH-1:0] mux_addr,
    output logic                    mux_ready_in,
    output logic [SELECT_WIDTH-1:0] demux_addr,
    output logic                    demux_avail_out,
    output logic [0:NUM_PORTS-1]    inflight,
    output logic                    busy,
    output logic [15:0]             issue_count
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                  state_reg;
    state_t                  state_next;
    logic [SELECT_WIDTH-1:0] last_grant_reg;
    logic [0:NUM_PORTS-1]    inflight_reg;
    logic [15:0]             count_reg;
    logic [PIPE_LATENCY-1:0] pipe_valid_reg;
    logic [SELECT_WIDTH-1:0] pipe_addr_reg [PIPE_LATENCY];

    logic [0:NUM_PORTS-1]    clear_hit;
    logic [0:NUM_PORTS-1]    eligible;
    logic [SELECT_WIDTH-1:0] grant;
    logic [SELECT_WIDTH-1:0] cand;
    logic                    any_eligible;
    logic                    issue;
    logic                    out_valid;
    logic [SELECT_WIDTH-1:0] out_addr;

    assign out_valid = pipe_valid_reg[PIPE_LATENCY-1];
    assign out_addr  = pipe_addr_reg[PIPE_LATENCY-1];

    // A context whose result leaves the core this cycle counts as free, so it
    // can be re-issued on the same edge that clears its inflight bit.
    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            assign clear_hit[gi] = out_valid && (out_addr == SELECT_WIDTH'(gi));
            assign eligible[gi]  = avail_inarray[gi] && ready_outarray[gi]
                                   && !(inflight_reg[gi] && !clear_hit[gi]);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    inflight_reg[gi] <= 1'b0;
                end else if (issue && grant == SELECT_WIDTH'(gi)) begin
                    inflight_reg[gi] <= 1'b1;
                end else if (clear_hit[gi]) begin
                    inflight_reg[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    // Scan from the farthest offset down so the nearest eligible context after
    // last_grant is the one that sticks.
    always_comb begin
        grant        = last_grant_reg;
        cand         = '0;
        any_eligible = 1'b0;
        for (int k = NUM_PORTS; k >= 1; k--) begin
            cand = SELECT_WIDTH'((int'(last_grant_reg) + k) % NUM_PORTS);
            if (eligible[cand]) begin
                grant        = cand;
                any_eligible = 1'b1;
            end
        end
    end

    assign issue = (state_reg == RUN) && any_eligible;

    generate
        for (genvar gi = 0; gi < PIPE_LATENCY; gi++) begin : g_pipe
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    pipe_valid_reg[gi] <= 1'b0;
                    pipe_addr_reg[gi]  <= '0;
                end else if (gi == 0) begin
                    pipe_valid_reg[gi] <= issue;
                    pipe_addr_reg[gi]  <= issue ? grant : '0;
                end else begin
                    pipe_valid_reg[gi] <= pipe_valid_reg[gi-1];
                    pipe_addr_reg[gi]  <= pipe_addr_reg[gi-1];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            last_grant_reg <= SELECT_WIDTH'(NUM_PORTS - 1);
            count_reg      <= '0;
        end else begin
            state_reg <= state_next;
            if (issue) begin
                last_grant_reg <= grant;
                count_reg      <= count_reg + 16'd1;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (enable) state_next = RUN;
            RUN:     if (!enable) state_next = DRAIN;
            DRAIN: begin
                if (enable) begin
                    state_next = RUN;
                end else if (pipe_valid_reg == '0 && inflight_reg == '0) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs are forced low for the whole reset pulse, including mux_addr,
    // which would otherwise show last_grant's reset value.
    always_comb begin
        mux_ready_in    = 1'b0;
        mux_addr        = '0;
        demux_avail_out = 1'b0;
        demux_addr      = '0;
        inflight        = '0;
        busy            = 1'b0;
        issue_count     = '0;
        if (!rst) begin
            mux_ready_in    = issue;
            mux_addr        = issue ? grant : last_grant_reg;
            demux_avail_out = out_valid;
            demux_addr      = out_valid ? out_addr : '0;
            inflight        = inflight_reg;
            busy            = (state_reg != IDLE) || (inflight_reg != '0);
            issue_count     = count_reg;
        end
    end

endmodule

// File: tb/tb_cspc_context_scheduler.sv
// Self-checking bench: a result-queue model of the scheduler is compared with the
// DUT on every cycle, plus a few literal checks on directed scenarios.
module tb_cspc_context_scheduler;
    localparam int N  = 4;
    localparam int L  = 3;
    localparam int SW = 2;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_DRAIN = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic [0:N-1]  avail;
    logic [0:N-1]  ready;
    logic [SW-1:0] mux_addr;
    logic          mux_ready_in;
    logic [SW-1:0] demux_addr;
    logic          demux_avail_out;
    logic [0:N-1]  inflight;
    logic          busy;
    logic [15:0]   issue_count;

    cspc_context_scheduler #(.NUM_PORTS(N), .PIPE_LATENCY(L)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .avail_inarray(avail), .ready_outarray(ready),
        .mux_addr(mux_addr), .mux_ready_in(mux_ready_in),
        .demux_addr(demux_addr), .demux_avail_out(demux_avail_out),
        .inflight(inflight), .busy(busy), .issue_count(issue_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: each issued word is a queue entry due out L cycles later.
    typedef struct { int due; int addr; } res_t;
    res_t q[$];
    int   m_state;
    bit   m_infl [N];
    int   m_last;
    int   m_count;
    int   cyc;
    bit   e_issue;
    int   e_grant;
    bit   e_valid;
    int   e_daddr;

    int   issued[$];
    int   n_pulse;
    int   n_strobe;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_state = M_IDLE;
        for (int p = 0; p < N; p++) m_infl[p] = 0;
        m_last  = N - 1;
        m_count = 0;
    endtask

    task automatic model_eval();
        bit elig;
        e_valid = (q.size() > 0) && (q[0].due == cyc);
        e_daddr = e_valid ? q[0].addr : 0;
        e_issue = 0;
        e_grant = m_last;
        if (m_state == M_RUN) begin
            for (int k = 1; k <= N; k++) begin
                int p;
                p = (m_last + k) % N;
                elig = avail[p] && ready[p] && !(m_infl[p] && !(e_valid && e_daddr == p));
                if (elig && !e_issue) begin
                    e_issue = 1;
                    e_grant = p;
                end
            end
        end
    endtask

    task automatic check_outputs();
        logic [N-1:0] exp_inf;
        logic [N-1:0] act_inf;
        bit any_inf;
        any_inf = 0;
        for (int p = 0; p < N; p++) begin
            exp_inf[p] = rst ? 1'b0 : m_infl[p];
            act_inf[p] = inflight[p];
            any_inf |= m_infl[p];
        end
        if (rst) begin
            chk("rst_mux_ready_in", 32'(mux_ready_in), 0);
            chk("rst_mux_addr", 32'(mux_addr), 0);
            chk("rst_demux_avail", 32'(demux_avail_out), 0);
            chk("rst_demux_addr", 32'(demux_addr), 0);
            chk("rst_inflight", 32'(act_inf), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_issue_count", 32'(issue_count), 0);
        end else begin
            chk("mux_ready_in", 32'(mux_ready_in), 32'(e_issue));
            chk("mux_addr", 32'(mux_addr), 32'(e_issue ? e_grant : m_last));
            chk("demux_avail_out", 32'(demux_avail_out), 32'(e_valid));
            chk("demux_addr", 32'(demux_addr), 32'(e_daddr));
            chk("inflight", 32'(act_inf), 32'(exp_inf));
            chk("busy", 32'(busy), 32'((m_state != M_IDLE) || any_inf));
            chk("issue_count", 32'(issue_count), 32'(m_count));
        end
    endtask

    task automatic model_step();
        bit any_inf;
        int nxt;
        if (rst) begin
            model_reset();
        end else begin
            any_inf = 0;
            for (int p = 0; p < N; p++) any_inf |= m_infl[p];
            nxt = m_state;
            case (m_state)
                M_IDLE:  if (enable) nxt = M_RUN;
                M_RUN:   if (!enable) nxt = M_DRAIN;
                default: if (enable) nxt = M_RUN;
                         else if (q.size() == 0 && !any_inf) nxt = M_IDLE;
            endcase
            if (e_valid) begin
                m_infl[e_daddr] = 0;
                void'(q.pop_front());
            end
            if (e_issue) begin
                m_infl[e_grant] = 1;
                q.push_back('{due: cyc + L, addr: e_grant});
                m_count = (m_count + 1) & 16'hFFFF;
                m_last  = e_grant;
            end
            m_state = nxt;
        end
        cyc++;
    endtask

    task automatic tick();
        @(negedge clk);
        model_eval();
        check_outputs();
        if (mux_ready_in === 1'b1) begin
            issued.push_back(int'(mux_addr));
            n_strobe++;
        end
        if (demux_avail_out === 1'b1) n_pulse++;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int cnt1;
        int guard;
        cyc = 0;
        model_reset();
        rst = 1'b1; enable = 1'b0; avail = '0; ready = '0;
        ticks(2);
        rst = 1'b0;

        // All eligible: rotation 0,1,2,3 and results L cycles later.
        enable = 1'b1; avail = '1; ready = '1;
        issued.delete();
        ticks(24);
        $display("all_eligible issues=%0d", issued.size());
        chk("rr_first0", 32'(issued[0]), 0);
        chk("rr_first1", 32'(issued[1]), 1);
        chk("rr_first2", 32'(issued[2]), 2);
        chk("rr_first3", 32'(issued[3]), 3);
        avail = '0;
        ticks(5);

        // Only context 2: one issue every L cycles.
        avail[2] = 1'b1;
        issued.delete();
        ticks(9);
        $display("sole_ctx2 issues=%0d", issued.size());
        chk("sole_issue_cnt", 32'(issued.size()), 3);
        for (int i = 0; i < issued.size(); i++) chk("sole_addr", 32'(issued[i]), 2);
        avail = '0;
        ticks(5);

        // Context 1 blocked on output space.
        avail = '1; ready = '1; ready[1] = 1'b0;
        issued.delete();
        ticks(20);
        cnt1 = 0;
        foreach (issued[i]) if (issued[i] == 1) cnt1++;
        $display("ctx1_blocked issues=%0d ctx1=%0d", issued.size(), cnt1);
        chk("ctx1_never", 32'(cnt1), 0);
        avail = '0; ready = '1;
        ticks(5);

        // Drop enable with two words in flight.
        avail[0] = 1'b1; avail[3] = 1'b1;
        issued.delete();
        ticks(2);
        chk("drain_two_issued", 32'(issued.size()), 2);
        enable = 1'b0;
        n_strobe = 0; n_pulse = 0;
        ticks(8);
        $display("drain strobes=%0d pulses=%0d busy=%0b", n_strobe, n_pulse, busy);
        chk("drain_no_strobe", 32'(n_strobe), 0);
        chk("drain_pulses", 32'(n_pulse), 2);
        chk("drain_idle_busy", 32'(busy), 0);

        // Reset one cycle after an issue.
        enable = 1'b1; avail = '1;
        ticks(2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        issued.delete();
        n_pulse = 0;
        ticks(3);
        $display("post_reset pulses=%0d first_grant=%0d", n_pulse, issued.size() > 0 ? issued[0] : -1);
        chk("post_reset_no_pulse", 32'(n_pulse), 0);
        chk("post_reset_grant0", 32'(issued.size() > 0 ? issued[0] : -1), 0);

        // Random traffic.
        for (int i = 0; i < 2500; i++) begin
            enable = ($urandom_range(0, 7) != 0);
            avail  = N'($urandom);
            ready  = N'($urandom) | N'($urandom);
            tick();
        end
        $display("random done issue_count=%0d", issue_count);

        // Sustained issues to carry issue_count across its wrap.
        enable = 1'b1; avail = '1; ready = '1;
        guard = 0;
        while (m_count < 16'hFFF0 && guard < 70000) begin
            tick();
            guard++;
        end
        if (guard >= 70000) chk("wrap_budget", 32'(guard), 0);
        ticks(40);
        $display("wrap issue_count=%0h", issue_count);
        chk("wrap_seen", 32'(issue_count < 16'h0030), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/cspc_context_scheduler.md
CSPC_CONTEXT_SCHEDULER -- requirements
Module: cspc_context_scheduler

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4, number of contexts (>=2).
REQ-002 SHALL have parameter PIPE_LATENCY, default 3, cycles from issue to result at the shared core output (>=1).
REQ-003 SHALL have localparam SELECT_WIDTH = countbits(NUM_PORTS-1), the context address width.
REQ-004 SHALL have port clk, input, 1, single clock; every register is on the rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port enable, input, 1, permits new issues.
REQ-007 SHALL have port avail_inarray, input, [0:NUM_PORTS-1], per-context input buffer holds a word.
REQ-008 SHALL have port ready_outarray, input, [0:NUM_PORTS-1], per-context output buffer can accept a word.
REQ-009 SHALL have port mux_addr, output, SELECT_WIDTH, context selected on the input multiplexer.
REQ-010 SHALL have port mux_ready_in, output, 1, consume strobe for the selected input buffer.
REQ-011 SHALL have port demux_addr, output, SELECT_WIDTH, context of the word leaving the core.
REQ-012 SHALL have port demux_avail_out, output, 1, a core result is valid this cycle.
REQ-013 SHALL have port inflight, output, [0:NUM_PORTS-1], context has a word in the core pipeline.
REQ-014 SHALL have port busy, output, 1, high when state!=IDLE or any inflight bit is set.
REQ-015 SHALL have port issue_count, output, 16, count of issues, wrapping at 16'hFFFF->0.

Function
REQ-016 SHALL treat context p as eligible when avail_inarray[p] & ready_outarray[p] & ~inflight[p].
REQ-017 SHALL compute the grant combinationally, round-robin: search starts at last_grant+1 mod NUM_PORTS and takes the first eligible context.
REQ-018 SHALL, in an issue cycle (state RUN and any eligible), drive mux_addr=grant and mux_ready_in=1, set inflight[grant] and update last_grant at the clock edge.
REQ-019 SHALL, in non-issue cycles, drive mux_ready_in=0 and hold mux_addr=last_grant.
REQ-020 SHALL carry {valid, addr} through a PIPE_LATENCY-deep shift register, so an issue at cycle t gives demux_avail_out=1 and demux_addr=grant at cycle t+PIPE_LATENCY.
REQ-021 SHALL clear inflight[demux_addr] at the edge ending a demux_avail_out=1 cycle.
REQ-022 SHALL, when a set and a clear of the same inflight bit fall on one edge, apply the clear first and then the set (set wins).
REQ-023 SHALL drive demux_addr=0 whenever demux_avail_out=0.
REQ-024 SHALL have FSM state IDLE: no issue; go to RUN when enable=1.
REQ-025 SHALL have FSM state RUN: issue per REQ-018; go to DRAIN when enable=0.
REQ-026 SHALL have FSM state DRAIN: no issue; go to RUN if enable=1, else go to IDLE when all valid stages and inflight are 0.
REQ-027 SHALL, at most, issue one context per cycle; a context never holds more than one word in flight, which guarantees output buffer space on arrival.
REQ-028 SHALL issue nothing when no context is eligible; last_grant is unchanged.
REQ-029 SHALL let a sole eligible context issue every cycle in which inflight is clear.

Reset
REQ-030 SHALL, on rst=1 (asynchronous, any time), set state=IDLE, last_grant=NUM_PORTS-1, pipeline valid=0, inflight=0 and issue_count=0.
REQ-031 SHALL drive all outputs to 0 while rst=1.
REQ-032 SHALL discard in-flight words when reset is asserted mid-operation; no demux_avail_out pulse follows deassertion.
REQ-033 SHALL make port 0 the first priority after reset.

Verification
REQ-034 SHALL cover: NUM_PORTS=4, PIPE_LATENCY=3, all eligible, enable=1 -> issues 0,1,2,3, each context re-issued only after its result; demux_avail_out pulses 3 cycles after each issue with matching addr.
REQ-035 SHALL cover: only context 2 eligible, ready_outarray[2] stays 1 -> issue, 3-cycle wait, then re-issue on the clear-then-set edge; issue_count increments by 1 per issue.
REQ-036 SHALL cover: ready_outarray[1]=0 with avail_inarray[1]=1 -> context 1 never granted; others rotate.
REQ-037 SHALL cover: enable dropped with 2 words in flight -> DRAIN, no mux_ready_in, both results emerge, then IDLE and busy=0.
REQ-038 SHALL cover: rst pulsed one cycle after an issue -> inflight=0 and no demux_avail_out; next grant after reset is context 0.
REQ-039 SHALL cover: issue_count preloaded near 16'hFFFF by sustained issues -> wraps to 0 without disturbing scheduling.
